// File: rtl/hamur_hakem.sv
// hamur_hakem: round-robin controller sharing one hamur dough unit between
// two requesters (tezgah 0 and 1). Accepts an order, drives the hamur unit
// until it reports bitti, then returns the results to the ordering tezgah.
//
// Optional feature: define HAMUR_ZAMAN_ASIMI_EN to abort a BEKLE wait after
// ZAMAN_ASIMI cycles without bitti. The abort returns zero data with a hata
// pulse. Without the macro, BEKLE waits forever and hata is tied low.
//
// Handshake: a requester holds istek[k] together with its ingredient slice
// until it sees the one-cycle kabul[k] pulse, then drops istek[k]. Ingredient
// inputs are sampled only in BOS, on the edge that grants the order. Results
// come back as a one-cycle sonuc_gecerli[k] pulse with sonuc_* valid in the
// same cycle. There is no back-pressure on the result side.
module hamur_hakem #(
    parameter int ZAMAN_ASIMI = 64
) (
    input  logic        saat,
    input  logic        reset,
    input  logic [1:0]  istek,
    input  logic [11:0] un_i,
    input  logic [15:0] su_i,
    input  logic [5:0]  tuz_i,
    input  logic [1:0]  maya_i,
    output logic [1:0]  kabul,
    output logic        basla,
    output logic [5:0]  un_miktari,
    output logic [7:0]  su_miktari,
    output logic [2:0]  tuz_miktari,
    output logic        maya,
    input  logic [1:0]  kalinlik,
    input  logic        mayali,
    input  logic        tuzlu,
    input  logic        bitti,
    output logic [1:0]  sonuc_gecerli,
    output logic [1:0]  sonuc_kalinlik,
    output logic        sonuc_mayali,
    output logic        sonuc_tuzlu,
    output logic        mesgul,
    output logic [7:0]  tamamlanan,
    output logic        hata
);

    // Elaboration-time guard: the timeout needs at least two BEKLE cycles.
    if (ZAMAN_ASIMI < 2) begin : g_zaman_asimi_check
        $error("hamur_hakem: ZAMAN_ASIMI must be >= 2");
    end

    typedef enum logic [1:0] {
        BOS    = 2'd0,
        BASLAT = 2'd1,
        BEKLE  = 2'd2,
        SONUC  = 2'd3
    } durum_t;

    durum_t      durum_q, durum_d;
    logic        oncelik_q, oncelik_d;          // tezgah that wins a tie
    logic        secilen_q, secilen_d;          // tezgah owning the current order
    logic [1:0]  kabul_q, kabul_d;
    logic        basla_q, basla_d;
    logic [5:0]  un_q, un_d;
    logic [7:0]  su_q, su_d;
    logic [2:0]  tuz_q, tuz_d;
    logic        maya_q, maya_d;
    logic [1:0]  sonuc_gecerli_q, sonuc_gecerli_d;
    logic [1:0]  sonuc_kalinlik_q, sonuc_kalinlik_d;
    logic        sonuc_mayali_q, sonuc_mayali_d;
    logic        sonuc_tuzlu_q, sonuc_tuzlu_d;
    logic        mesgul_q, mesgul_d;
    logic [7:0]  tamamlanan_q, tamamlanan_d;
    logic        kazanan;                       // grant candidate in BOS

`ifdef HAMUR_ZAMAN_ASIMI_EN
    localparam logic [7:0] SINIR = 8'(ZAMAN_ASIMI - 1);
    logic [7:0]  sayac_q, sayac_d;              // BEKLE cycles elapsed
    logic        hata_q, hata_d;
`endif

    // Next-state and registered-output computation for the order FSM.
    always_comb begin
        durum_d          = durum_q;
        oncelik_d        = oncelik_q;
        secilen_d        = secilen_q;
        kabul_d          = 2'b00;
        basla_d          = basla_q;
        un_d             = un_q;
        su_d             = su_q;
        tuz_d            = tuz_q;
        maya_d           = maya_q;
        sonuc_gecerli_d  = 2'b00;
        sonuc_kalinlik_d = sonuc_kalinlik_q;
        sonuc_mayali_d   = sonuc_mayali_q;
        sonuc_tuzlu_d    = sonuc_tuzlu_q;
        mesgul_d         = mesgul_q;
        tamamlanan_d     = tamamlanan_q;
`ifdef HAMUR_ZAMAN_ASIMI_EN
        sayac_d          = sayac_q;
        hata_d           = 1'b0;
`endif
        // The priority side wins whenever it is requesting.
        kazanan = istek[oncelik_q] ? oncelik_q : ~oncelik_q;

        case (durum_q)
            BOS: begin
                if (istek != 2'b00) begin
                    durum_d   = BASLAT;
                    secilen_d = kazanan;
                    kabul_d   = {kazanan, ~kazanan};
                    basla_d   = 1'b1;
                    mesgul_d  = 1'b1;
                    un_d      = kazanan ? un_i[11:6]  : un_i[5:0];
                    su_d      = kazanan ? su_i[15:8]  : su_i[7:0];
                    tuz_d     = kazanan ? tuz_i[5:3]  : tuz_i[2:0];
                    maya_d    = maya_i[kazanan];
                end
            end
            BASLAT: begin
                durum_d = BEKLE;
`ifdef HAMUR_ZAMAN_ASIMI_EN
                sayac_d = 8'd0;
`endif
            end
            BEKLE: begin
                if (bitti) begin
                    durum_d          = SONUC;
                    sonuc_gecerli_d  = {secilen_q, ~secilen_q};
                    sonuc_kalinlik_d = kalinlik;
                    sonuc_mayali_d   = mayali;
                    sonuc_tuzlu_d    = tuzlu;
                    oncelik_d        = ~secilen_q;
                    if (tamamlanan_q != 8'hFF) begin
                        tamamlanan_d = tamamlanan_q + 8'd1;
                    end
                end
`ifdef HAMUR_ZAMAN_ASIMI_EN
                else if (sayac_q == SINIR) begin
                    // Aborted order: zero data, flagged, not counted.
                    durum_d          = SONUC;
                    sonuc_gecerli_d  = {secilen_q, ~secilen_q};
                    sonuc_kalinlik_d = 2'b00;
                    sonuc_mayali_d   = 1'b0;
                    sonuc_tuzlu_d    = 1'b0;
                    oncelik_d        = ~secilen_q;
                    hata_d           = 1'b1;
                end else begin
                    sayac_d = sayac_q + 8'd1;
                end
`endif
            end
            SONUC: begin
                // Leaving for BOS: release the hamur unit.
                durum_d  = BOS;
                basla_d  = 1'b0;
                mesgul_d = 1'b0;
                un_d     = 6'd0;
                su_d     = 8'd0;
                tuz_d    = 3'd0;
                maya_d   = 1'b0;
            end
            default: durum_d = BOS;
        endcase
    end

    // State and output registers; reset drops everything back to idle.
    always_ff @(posedge saat or negedge reset) begin
        if (!reset) begin
            durum_q          <= BOS;
            oncelik_q        <= 1'b0;
            secilen_q        <= 1'b0;
            kabul_q          <= 2'b00;
            basla_q          <= 1'b0;
            un_q             <= 6'd0;
            su_q             <= 8'd0;
            tuz_q            <= 3'd0;
            maya_q           <= 1'b0;
            sonuc_gecerli_q  <= 2'b00;
            sonuc_kalinlik_q <= 2'b00;
            sonuc_mayali_q   <= 1'b0;
            sonuc_tuzlu_q    <= 1'b0;
            mesgul_q         <= 1'b0;
            tamamlanan_q     <= 8'd0;
`ifdef HAMUR_ZAMAN_ASIMI_EN
            sayac_q          <= 8'd0;
            hata_q           <= 1'b0;
`endif
        end else begin
            durum_q          <= durum_d;
            oncelik_q        <= oncelik_d;
            secilen_q        <= secilen_d;
            kabul_q          <= kabul_d;
            basla_q          <= basla_d;
            un_q             <= un_d;
            su_q             <= su_d;
            tuz_q            <= tuz_d;
            maya_q           <= maya_d;
            sonuc_gecerli_q  <= sonuc_gecerli_d;
            sonuc_kalinlik_q <= sonuc_kalinlik_d;
            sonuc_mayali_q   <= sonuc_mayali_d;
            sonuc_tuzlu_q    <= sonuc_tuzlu_d;
            mesgul_q         <= mesgul_d;
            tamamlanan_q     <= tamamlanan_d;
`ifdef HAMUR_ZAMAN_ASIMI_EN
            sayac_q          <= sayac_d;
            hata_q           <= hata_d;
`endif
        end
    end

    assign kabul          = kabul_q;
    assign basla          = basla_q;
    assign un_miktari     = un_q;
    assign su_miktari     = su_q;
    assign tuz_miktari    = tuz_q;
    assign maya           = maya_q;
    assign sonuc_gecerli  = sonuc_gecerli_q;
    assign sonuc_kalinlik = sonuc_kalinlik_q;
    assign sonuc_mayali   = sonuc_mayali_q;
    assign sonuc_tuzlu    = sonuc_tuzlu_q;
    assign mesgul         = mesgul_q;
    assign tamamlanan     = tamamlanan_q;
`ifdef HAMUR_ZAMAN_ASIMI_EN
    assign hata           = hata_q;
`else
    assign hata           = 1'b0;
`endif

endmodule

// File: tb/tb_hamur_hakem.sv
// Testbench for hamur_hakem: random and directed orders from both tezgah,
// a behavioural hamur unit, and a scoreboard of expected grants/results.
module tb_hamur_hakem;

    localparam int ZA = 4;

    logic        saat = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  istek = 2'b00;
    logic [11:0] un_i = '0;
    logic [15:0] su_i = '0;
    logic [5:0]  tuz_i = '0;
    logic [1:0]  maya_i = '0;
    logic [1:0]  kabul;
    logic        basla;
    logic [5:0]  un_miktari;
    logic [7:0]  su_miktari;
    logic [2:0]  tuz_miktari;
    logic        maya;
    logic [1:0]  kalinlik = 2'b00;
    logic        mayali = 1'b0;
    logic        tuzlu = 1'b0;
    logic        bitti = 1'b0;
    logic [1:0]  sonuc_gecerli;
    logic [1:0]  sonuc_kalinlik;
    logic        sonuc_mayali;
    logic        sonuc_tuzlu;
    logic        mesgul;
    logic [7:0]  tamamlanan;
    logic        hata;

    hamur_hakem #(.ZAMAN_ASIMI(ZA)) dut (
        .saat(saat), .reset(reset), .istek(istek),
        .un_i(un_i), .su_i(su_i), .tuz_i(tuz_i), .maya_i(maya_i),
        .kabul(kabul), .basla(basla),
        .un_miktari(un_miktari), .su_miktari(su_miktari),
        .tuz_miktari(tuz_miktari), .maya(maya),
        .kalinlik(kalinlik), .mayali(mayali), .tuzlu(tuzlu), .bitti(bitti),
        .sonuc_gecerli(sonuc_gecerli), .sonuc_kalinlik(sonuc_kalinlik),
        .sonuc_mayali(sonuc_mayali), .sonuc_tuzlu(sonuc_tuzlu),
        .mesgul(mesgul), .tamamlanan(tamamlanan), .hata(hata)
    );

    wire [36:0] all_out = {kabul, basla, un_miktari, su_miktari, tuz_miktari,
                           maya, sonuc_gecerli, sonuc_kalinlik, sonuc_mayali,
                           sonuc_tuzlu, mesgul, tamamlanan, hata};

    // ---------------- clock / cycle counter ----------------
    always #5 saat = ~saat;
    int cyc = 0;
    always @(posedge saat) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_err = 0;
    // ingredient word: {un[5:0], su[7:0], tuz[2:0], maya}
    // order word:      {delay[7:0], ingredient}
    logic [25:0] ord0_q[$];
    logic [25:0] ord1_q[$];
    logic [19:0] gnt_q[$];          // {kabul one-hot, ingredient}
    int          gnt_cyc_q[$];
    logic [14:0] exp_q[$];          // {gecerli, kal, may, tuz, hata, tamamlanan}
    int          exp_cyc_q[$];
    int          hm_dly_q[$];
    logic        m_ptr = 1'b0;
    logic [7:0]  m_tam = 8'd0;
    logic        busy = 1'b0;
    logic [17:0] cur_ing = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: event missing or unexpected (t=%0t)", name, $time);
    endtask

    // Behaviour of the hamur unit: returns {kalinlik, mayali, tuzlu}.
    function automatic logic [3:0] hamur_fn(input logic [17:0] ing);
        logic [1:0] k;
        if (ing[17:12] >= 6'd48)      k = 2'd2;
        else if (ing[17:12] >= 6'd32) k = 2'd1;
        else if (ing[11:4] >= 8'd200) k = 2'd3;
        else                          k = 2'd0;
        return {k, ing[0], (ing[3:1] >= 3'd4)};
    endfunction

    // ---------------- hamur model + monitor ----------------
    logic        hm_run = 1'b0;
    logic        hm_done = 1'b0;
    int          hm_cnt = 0;
    int          hm_d = 0;
    logic [19:0] g;
    logic [14:0] e;
    int          gc;
    int          ec;

    always @(negedge saat) begin
        if (!reset) begin
            busy = 1'b0; hm_run = 1'b0; hm_done = 1'b0; hm_cnt = 0; bitti = 1'b0;
        end else begin
            // hamur unit: bitti one cycle, hm_d cycles after the start cycle
            bitti = 1'b0;
            if (!basla) begin
                hm_run = 1'b0; hm_done = 1'b0;
            end else if (!hm_run && !hm_done) begin
                hm_run = 1'b1; hm_cnt = 0;
                hm_d = (hm_dly_q.size() > 0) ? hm_dly_q.pop_front() : 0;
            end else if (hm_run) begin
                if (hm_cnt == hm_d) begin
                    {kalinlik, mayali, tuzlu} = hamur_fn({un_miktari, su_miktari, tuz_miktari, maya});
                    bitti = 1'b1; hm_run = 1'b0; hm_done = 1'b1;
                end else begin
                    hm_cnt++;
                end
            end
            // grant side
            if (kabul != 2'b00 && sonuc_gecerli != 2'b00) fail("kabul_sonuc_overlap");
            if (kabul != 2'b00) begin
                if (gnt_q.size() == 0) fail("unexpected_kabul");
                else begin
                    g = gnt_q.pop_front(); gc = gnt_cyc_q.pop_front();
                    check("kabul", {kabul, un_miktari, su_miktari, tuz_miktari, maya}, g);
                    check("kabul_cycle", cyc, gc);
                    cur_ing = g[17:0];
                    busy = 1'b1;
                end
            end
            // hamur-side outputs: held while busy, zero while idle
            if (busy) check("hold", {basla, mesgul, un_miktari, su_miktari, tuz_miktari, maya}, {2'b11, cur_ing});
            else      check("idle", {basla, mesgul, un_miktari, su_miktari, tuz_miktari, maya}, 20'd0);
            if (sonuc_gecerli == 2'b00) check("hata_quiet", hata, 0);
            // result side
            if (sonuc_gecerli != 2'b00) begin
                if (exp_q.size() == 0) fail("unexpected_sonuc");
                else begin
                    e = exp_q.pop_front(); ec = exp_cyc_q.pop_front();
                    check("sonuc", {sonuc_gecerli, sonuc_kalinlik, sonuc_mayali, sonuc_tuzlu, hata, tamamlanan}, e);
                    check("sonuc_cycle", cyc, ec);
                end
                busy = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic present(input int k);
        logic [17:0] ing;
        logic        have;
        logic [25:0] o;
        if (k == 0) begin
            have = (ord0_q.size() > 0);
            if (have) begin o = ord0_q[0]; ing = o[17:0]; end else ing = 18'($urandom);
            istek[0] = have;
            un_i[5:0] = ing[17:12]; su_i[7:0] = ing[11:4]; tuz_i[2:0] = ing[3:1]; maya_i[0] = ing[0];
        end else begin
            have = (ord1_q.size() > 0);
            if (have) begin o = ord1_q[0]; ing = o[17:0]; end else ing = 18'($urandom);
            istek[1] = have;
            un_i[11:6] = ing[17:12]; su_i[15:8] = ing[11:4]; tuz_i[5:3] = ing[3:1]; maya_i[1] = ing[0];
        end
    endtask

    task automatic clear_queues();
        gnt_q.delete(); gnt_cyc_q.delete(); exp_q.delete(); exp_cyc_q.delete();
        hm_dly_q.delete(); ord0_q.delete(); ord1_q.delete();
    endtask

    // Serve everything queued in ord0_q/ord1_q. Called at a negedge with the
    // DUT idle. The reference model first predicts grant order, grant/result
    // cycles and results from the arbitration rules, then requests are driven.
    task automatic run_orders();
        logic [25:0] a0[$];
        logic [25:0] a1[$];
        logic [25:0] o;
        logic [3:0]  r;
        logic        p;
        logic        w;
        int          t;
        int          d;
        int          sc;
        int          budget;
        a0 = ord0_q; a1 = ord1_q; p = m_ptr; t = cyc + 1; budget = 100;
        while (a0.size() + a1.size() > 0) begin
            if (p == 1'b0) w = (a0.size() > 0) ? 1'b0 : 1'b1;
            else           w = (a1.size() > 0) ? 1'b1 : 1'b0;
            o = w ? a1.pop_front() : a0.pop_front();
            d = int'(o[25:18]);
            gnt_q.push_back({w, ~w, o[17:0]}); gnt_cyc_q.push_back(t);
            hm_dly_q.push_back(d);
            r = hamur_fn(o[17:0]);
`ifdef HAMUR_ZAMAN_ASIMI_EN
            if (d >= ZA) begin
                exp_q.push_back({w, ~w, 4'b0000, 1'b1, m_tam});
                sc = t + 1 + ZA;
            end else
`endif
            begin
                if (m_tam != 8'hFF) m_tam = m_tam + 8'd1;
                exp_q.push_back({w, ~w, r, 1'b0, m_tam});
                sc = t + 2 + d;
            end
            exp_cyc_q.push_back(sc);
            p = ~w; t = sc + 2; budget += d + 10;
        end
        m_ptr = p;
        present(0); present(1);
        for (int c = 0; c < budget && (ord0_q.size() + ord1_q.size()) > 0; c++) begin
            @(negedge saat);
            if (kabul[0] && ord0_q.size() > 0) begin void'(ord0_q.pop_front()); present(0); end
            if (kabul[1] && ord1_q.size() > 0) begin void'(ord1_q.pop_front()); present(1); end
        end
        if (ord0_q.size() + ord1_q.size() > 0) fail("grant_timeout");
        ord0_q.delete(); ord1_q.delete(); istek = 2'b00;
        for (int c = 0; c < budget && (exp_q.size() > 0 || busy); c++) @(negedge saat);
        if (exp_q.size() > 0 || gnt_q.size() > 0) fail("drain_timeout");
        clear_queues();
        repeat (2) @(negedge saat);
    endtask

    task automatic add_rand(input int k, input int n, input int dmax);
        for (int i = 0; i < n; i++) begin
            if (k == 0) ord0_q.push_back({8'($urandom_range(0, dmax)), 18'($urandom)});
            else        ord1_q.push_back({8'($urandom_range(0, dmax)), 18'($urandom)});
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [17:0] ing;
        logic        seen;
        #2 reset = 1'b0;
        #10 check("reset_state", all_out, 37'd0);
        repeat (2) @(negedge saat);
        reset = 1'b1;
        @(negedge saat);

        // tezgah0 full-scale order, hamur answers at once
        ord0_q.push_back({8'd0, 6'd63, 8'd255, 3'd7, 1'b1});
        run_orders();
        // tezgah1 order with bitti delayed 5 cycles
        ord1_q.push_back({8'd5, 6'd25, 8'd142, 3'd2, 1'b1});
        run_orders();
        // continuous contention: 4 orders, alternating grants
        add_rand(0, 2, 0); add_rand(1, 2, 0);
        run_orders();
        // random mixes
        for (int i = 0; i < 6; i++) begin
            add_rand(0, $urandom_range(0, 3), 6);
            add_rand(1, $urandom_range(0, 3), 6);
            run_orders();
        end
        // timeout boundary (bitti just in time, just too late, never)
        ord0_q.push_back({8'(ZA - 1), 18'($urandom)});
        ord1_q.push_back({8'(ZA), 18'($urandom)});
        ord0_q.push_back({8'd50, 18'($urandom)});
        run_orders();
        // leave priority at tezgah1 before the reset test
        add_rand(0, 1, 2);
        run_orders();

        // reset during BEKLE of a tezgah1 order
        ing = 18'($urandom);
        ord1_q.push_back({8'd40, ing});
        gnt_q.push_back({2'b10, ing}); gnt_cyc_q.push_back(cyc + 1); hm_dly_q.push_back(40);
        present(1);
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge saat);
            if (kabul[1]) seen = 1'b1;
        end
        if (!seen) fail("reset_test_kabul");
        ord1_q.delete(); present(1);
        repeat (4) @(negedge saat);
        @(posedge saat); #2 reset = 1'b0;
        #1 check("reset_mid_order", all_out, 37'd0);
        clear_queues(); m_ptr = 1'b0; m_tam = 8'd0;
        repeat (3) @(negedge saat);
        reset = 1'b1;
        repeat (50) @(negedge saat);
        add_rand(0, 1, 1); add_rand(1, 1, 1);
        run_orders();

        // saturation of the completed-order counter
        add_rand(0, 130, 0); add_rand(1, 130, 0);
        run_orders();
        check("tamamlanan_saturated", tamamlanan, 8'd255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/hamur_hakem.md
# hamur_hakem

Round-robin controller that shares one `hamur` dough unit between two requesters (tezgah 0 and 1). It accepts an order, latches its ingredient amounts, runs the `hamur` unit with `basla`, waits for `bitti`, and returns `kalinlik`/`mayali`/`tuzlu` to the requester that placed the order. It sits between the order-entry logic and the `hamur` instance, and is the only block that drives `hamur` inputs.

## Interface
- ZAMAN_ASIMI, 64: max BEKLE cycles before abort; used only with the macro in Configuration; ≥2.
- saat  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous reset, active-low
- istek  in  2  per-requester order request; bit k = tezgah k
- un_i  in  12  flour amounts, {tezgah1[11:6], tezgah0[5:0]}
- su_i  in  16  water amounts, {tezgah1[15:8], tezgah0[7:0]}
- tuz_i  in  6  salt amounts, {tezgah1[5:3], tezgah0[2:0]}
- maya_i  in  2  yeast flags, bit k = tezgah k
- kabul  out  2  one-hot order-accepted pulse
- basla  out  1  to hamur: start/hold
- un_miktari  out  6  to hamur
- su_miktari  out  8  to hamur
- tuz_miktari  out  3  to hamur
- maya  out  1  to hamur
- kalinlik  in  2  from hamur
- mayali  in  1  from hamur
- tuzlu  in  1  from hamur
- bitti  in  1  from hamur
- sonuc_gecerli  out  2  one-hot result-valid pulse
- sonuc_kalinlik  out  2  returned thickness
- sonuc_mayali  out  1  returned yeast flag
- sonuc_tuzlu  out  1  returned salt flag
- mesgul  out  1  high in every state except BOS
- tamamlanan  out  8  completed-order count, saturating at 255
- hata  out  1  timeout pulse (Configuration)

## Operation
- All outputs registered. Reset values: every output 0; state BOS; priority pointer `oncelik` = 0.
- States: BOS → BASLAT → BEKLE → SONUC → BOS.
- BOS: if `istek` ≠ 0, grant k = `oncelik` when `istek[oncelik]` is set, else the other set bit. Latch tezgah k's un/su/tuz/maya slices and k. Go to BASLAT. If `istek` = 0, stay.
- BASLAT, one cycle: `kabul[k]`=1; `basla`=1; `un_miktari`/`su_miktari`/`tuz_miktari`/`maya` hold the latched values. Next state is BEKLE unconditionally.
- BEKLE: `basla` stays 1 and the ingredient outputs stay held. When `bitti`=1 at an edge, capture kalinlik/mayali/tuzlu into the `sonuc_*` registers and go to SONUC.
- SONUC, one cycle:
  - `sonuc_gecerli[k]`=1 with captured results.
  - `basla`=1.
  - `tamamlanan` += 1 unless it is already 255.
  - `oncelik` ← 1−k.
  - Next state BOS.
- In BOS, `basla` and the hamur ingredient outputs are 0. `sonuc_*` data holds its last value.
- Requester protocol: hold `istek[k]` and the ingredient slice until `kabul[k]` is seen, then deassert. Ingredient inputs are sampled only in BOS. If `istek[k]` is still high when the block returns to BOS, it is a new order.
- Both `istek` bits high: the `oncelik` side wins. Alternation is therefore guaranteed under continuous contention.
- Reset asserted mid-order: immediate return to reset values. The order is lost, no `sonuc_gecerli` is produced, and the requester must re-request.

## Timing
- `istek[k]` high at edge t in BOS:
  - `kabul[k]` and `basla` high during cycle t+1 (BASLAT).
  - BEKLE from t+2.
- `bitti` already high at the first BEKLE edge: `sonuc_gecerli[k]` high during cycle t+3. This is the minimum latency, 3 cycles.
- Each extra cycle `bitti` stays low adds one cycle.
- Back-to-back orders: the next BASLAT is no earlier than 2 cycles after SONUC (SONUC → BOS → BASLAT).
- `kabul` and `sonuc_gecerli` are each exactly one cycle wide and never high in the same cycle.

## Configuration
- `HAMUR_ZAMAN_ASIMI_EN` defined:
  - An 8-bit BEKLE counter starts at 0 on BEKLE entry.
  - If `bitti` is still 0 after ZAMAN_ASIMI BEKLE cycles, go to SONUC with `sonuc_*` data = 0.
  - In that SONUC cycle, `sonuc_gecerli[k]`=1 and `hata`=1 together.
  - `tamamlanan` is not incremented; `oncelik` still flips.
- Not defined: BEKLE waits indefinitely, `hata` is tied to 0, and no counter is built.

## Test plan
- Reset, then tezgah0 un=63 su=255 tuz=7 maya=1 with a hamur model returning bitti immediately → `kabul`=01 at t+1, `sonuc_gecerli`=01 at t+3, kalinlik=2, mayali=1, tuzlu=1, `tamamlanan`=1.
- Both `istek`=11 held continuously for 4 orders → grants ordered 0,1,0,1; `tamamlanan`=4; no cycle with two bits of `kabul` set.
- tezgah1 un=25 su=142 tuz=2 maya=1 with `bitti` delayed 5 cycles → `basla` and `un_miktari`=25 stable for the whole BEKLE period; `sonuc_gecerli`=10 at t+8, kalinlik=0, mayali=1, tuzlu=0.
- Reset low during BEKLE → all outputs 0 immediately; no `sonuc_gecerli` afterwards; the next order is served from tezgah0 priority.
- 256 completed orders → `tamamlanan` stays 255.
- `HAMUR_ZAMAN_ASIMI_EN`, ZAMAN_ASIMI=4, `bitti` held 0 → `hata`=1 and `sonuc_gecerli[k]`=1 in the same cycle, data 0, `tamamlanan` unchanged.
